// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide sequencer owning HI/LO with fixed-latency busy.
// Define MDU_MADD_EN to compile in the MADD/MADDU/MSUB/MSUBU accumulate ops (9-12).
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic        req,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hl_out
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, stateNext;
  logic [31:0] hi, lo, tmpHi, tmpLo;
  logic [CW-1:0] cnt;
  logic accept, isDiv, isLong;
  logic signed [63:0] extA, extB, prodS;
  logic [63:0] prodU, res;
  logic [31:0] rtSafe, absA, absB, dvd, dvs, uq, ur, quo, rem;
  assign accept = start && !req && state == IDLE;
  assign isDiv = op == 4'd3 || op == 4'd4;
`ifdef MDU_MADD_EN
  assign isLong = (op >= 4'd1 && op <= 4'd4) || (op >= 4'd9 && op <= 4'd12);
`else
  assign isLong = op >= 4'd1 && op <= 4'd4;
`endif
  assign extA = {{32{rs_data[31]}}, rs_data};
  assign extB = {{32{rt_data[31]}}, rt_data};
  assign prodS = extA * extB;
  assign prodU = {32'b0, rs_data} * {32'b0, rt_data};
  // One unsigned divider serves both flavours; signed works on magnitudes, which also makes 0x80000000/-1 wrap cleanly.
  assign rtSafe = (rt_data == 32'b0) ? 32'd1 : rt_data;
  assign absA = rs_data[31] ? -rs_data : rs_data;
  assign absB = rtSafe[31] ? -rtSafe : rtSafe;
  assign dvd = (op == 4'd3) ? absA : rs_data;
  assign dvs = (op == 4'd3) ? absB : rtSafe;
  assign uq = dvd / dvs;
  assign ur = dvd % dvs;
  assign quo = (op == 4'd3 && (rs_data[31] ^ rt_data[31])) ? -uq : uq;
  assign rem = (op == 4'd3 && rs_data[31]) ? -ur : ur;
  always_comb begin
    res = {hi, lo};
    if (op == 4'd1) res = prodS;
    else if (op == 4'd2) res = prodU;
    else if (isDiv && rt_data != 32'b0) res = {rem, quo};
`ifdef MDU_MADD_EN
    else if (op == 4'd9) res = {hi, lo} + prodS;
    else if (op == 4'd10) res = {hi, lo} + prodU;
    else if (op == 4'd11) res = {hi, lo} - prodS;
    else if (op == 4'd12) res = {hi, lo} - prodU;
`endif
  end
  always_comb begin
    stateNext = state;
    if (state == IDLE && accept && isLong) stateNext = RUN;
    else if (state == RUN && cnt == CW'(1)) stateNext = IDLE;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : stateNext;
  // Divide by zero reloads the current HI/LO, so completion leaves them unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
      tmpHi <= '0;
      tmpLo <= '0;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (accept && isLong) begin
        {tmpHi, tmpLo} <= res;
        cnt <= isDiv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (accept && op == 4'd5) hi <= rs_data;
      else if (accept && op == 4'd6) lo <= rs_data;
    end else begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) {hi, lo} <= {tmpHi, tmpLo};
    end
  end
  assign busy = state == RUN;
  assign hl_out = (op == 4'd7) ? hi : (op == 4'd8) ? lo : 32'b0;
endmodule
